// File: rtl/cpu_pkg.sv
// cpu_pkg: shared RV32M divider encodings, state type and constants
package cpu_pkg;
  localparam int XLEN_RV32 = 32;
  localparam logic [1:0] DIV_OP_DIV = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;
  localparam int DIV_ITERS = XLEN_RV32;
  localparam logic [XLEN_RV32-1:0] DIV_ZERO_Q = '1;
  localparam logic [XLEN_RV32-1:0] DIV_OVF_DIVIDEND = {1'b1, {(XLEN_RV32-1){1'b0}}};
  localparam logic [XLEN_RV32-1:0] DIV_OVF_DIVISOR = '1;
  localparam logic [XLEN_RV32-1:0] DIV_OVF_Q = DIV_OVF_DIVIDEND;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_t;
endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one combinational radix-2 restoring step (shift in dividend bit, trial subtract)
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] dvs,
  input  logic            msb,
  output logic [XLEN:0]   rem_nxt,
  output logic            q
);
  logic [XLEN+1:0] shifted, diff;
  // top bit of diff is the borrow; keep the difference only when it did not go negative
  always_comb begin
    shifted = {rem, msb};
    diff = shifted - {2'b00, dvs};
    q = ~diff[XLEN+1];
    rem_nxt = q ? diff[XLEN:0] : shifted[XLEN:0];
  end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle RV32M DIV/DIVU/REM/REMU; optional early-out via DIV_EARLY_OUT_EN
module seq_divider
  import cpu_pkg::*;
#(
  parameter int XLEN = DIV_ITERS
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic            kill,
  output logic            div_running,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] ALL1 = '1;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  div_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [XLEN:0] rem, rem_n;
  logic [XLEN-1:0] quo, dvs, abs_a, abs_b, fast_res, fix_res;
  logic is_rem_r, neg_q, neg_r, q_bit;
  logic sgn, neg_a, neg_b, accept, by_zero, ovf, early, fast, last;
  div_step #(.XLEN(XLEN)) u_step (
    .rem(rem),
    .dvs(dvs),
    .msb(quo[XLEN-1]),
    .rem_nxt(rem_n),
    .q(q_bit)
  );
  // operand magnitudes, fast-path detection and handshake outputs
  always_comb begin
    sgn = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    neg_a = sgn & opA[XLEN-1];
    neg_b = sgn & opB[XLEN-1];
    abs_a = neg_a ? -opA : opA;
    abs_b = neg_b ? -opB : opB;
    by_zero = opB == '0;
    ovf = sgn && opA == MIN && opB == ALL1;
`ifdef DIV_EARLY_OUT_EN
    early = abs_b > abs_a;
`else
    early = 1'b0;
`endif
    fast = by_zero | ovf | early;
    fast_res = op[1] ? ((by_zero | early) ? opA : '0) : (by_zero ? ALL1 : ovf ? MIN : '0);
    accept = state == IDLE && start && !kill;
    last = cnt == CW'(XLEN - 1);
    div_running = nrst && !kill && (accept || state == RUN || state == FIX);
    done = state == DONE && !kill;
    fix_res = is_rem_r ? (neg_r ? -rem[XLEN-1:0] : rem[XLEN-1:0]) : (neg_q ? -quo : quo);
    state_n = kill ? IDLE :
              state == IDLE ? (start ? (fast ? DONE : RUN) : IDLE) :
              state == RUN ? (last ? FIX : RUN) :
              state == FIX ? DONE : IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else state <= state_n;
  end
  // datapath: latch on accept, one quotient bit per RUN cycle, sign fix-up in FIX
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      is_rem_r <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      result <= '0;
    end else if (!kill) begin
      if (accept) begin
        is_rem_r <= op[1];
        neg_q <= neg_a ^ neg_b;
        neg_r <= neg_a;
        rem <= '0;
        quo <= abs_a;
        dvs <= abs_b;
        cnt <= '0;
        if (fast) result <= fast_res;
      end else if (state == RUN) begin
        rem <= rem_n;
        quo <= {quo[XLEN-2:0], q_bit};
        cnt <= cnt + 1'b1;
      end else if (state == FIX) result <= fix_res;
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed self-checking bench for seq_divider
module tb_seq_divider;
  logic clk, nrst, start, kill;
  logic [1:0] op;
  logic [31:0] opA, opB, result, last_res;
  logic div_running, done;
  int tests = 0;
  int fails = 0;
  int n_done;
  seq_divider #(.XLEN(32)) dut (
    .clk(clk),
    .nrst(nrst),
    .start(start),
    .op(op),
    .opA(opA),
    .opB(opB),
    .kill(kill),
    .div_running(div_running),
    .done(done),
    .result(result)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input int exp_lat, input bit keep);
    int done_at;
    int runs;
    logic [31:0] got;
    done_at = -1;
    runs = 0;
    got = 'x;
    @(negedge clk);
    start = 1'b1;
    op = o;
    opA = a;
    opB = b;
    for (int k = 0; k < 60 && done_at < 0; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (div_running) runs++;
      if (done) begin
        done_at = k;
        got = result;
      end
    end
    if (!keep) start = 1'b0;
    last_res = got;
    chk({tag, " latency"}, 32'(done_at), 32'(exp_lat));
    chk({tag, " running"}, 32'(runs), 32'(exp_lat));
    chk({tag, " result"}, got, exp_r);
  endtask
  initial begin
    nrst = 1'b0;
    start = 1'b1;
    kill = 1'b0;
    op = 2'b01;
    opA = 32'd5;
    opB = 32'd0;
    last_res = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset running", {31'd0, div_running}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    start = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    run_op("div 100/7", 2'b00, 32'd100, 32'd7, 32'd14, 34, 1'b0);
    run_op("rem 100/7", 2'b10, 32'd100, 32'd7, 32'd2, 34, 1'b0);
    run_op("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b0);
    run_op("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b0);
    run_op("divu big/2", 2'b01, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 34, 1'b0);
    run_op("div 100/-7", 2'b00, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34, 1'b0);
    run_op("rem -100/7", 2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34, 1'b0);
    run_op("div min/1", 2'b00, 32'h8000_0000, 32'd1, 32'h8000_0000, 34, 1'b0);
    run_op("divu 5/0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("remu 5/0", 2'b11, 32'd5, 32'd0, 32'd5, 1, 1'b0);
    run_op("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
    run_op("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
`ifdef DIV_EARLY_OUT_EN
    run_op("divu 3/10", 2'b01, 32'd3, 32'd10, 32'd0, 1, 1'b0);
    run_op("remu 3/10", 2'b11, 32'd3, 32'd10, 32'd3, 1, 1'b0);
`else
    run_op("divu 3/10", 2'b01, 32'd3, 32'd10, 32'd0, 34, 1'b0);
    run_op("remu 3/10", 2'b11, 32'd3, 32'd10, 32'd3, 34, 1'b0);
`endif
    run_op("held divu", 2'b01, 32'd1000, 32'd3, 32'd333, 34, 1'b1);
    run_op("b2b divu", 2'b01, 32'd1000, 32'd7, 32'd142, 34, 1'b0);
    @(negedge clk);
    start = 1'b1;
    op = 2'b00;
    opA = 32'd1000;
    opB = 32'd3;
    repeat (10) @(negedge clk);
    kill = 1'b1;
    #1;
    chk("kill running", {31'd0, div_running}, 32'd0);
    @(negedge clk);
    kill = 1'b0;
    start = 1'b0;
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (done) n_done++;
      @(negedge clk);
    end
    chk("kill no done", 32'(n_done), 32'd0);
    chk("kill result kept", result, last_res);
    start = 1'b1;
    op = 2'b01;
    opA = 32'h1234_5678;
    opB = 32'h10;
    repeat (20) @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("mid reset running", {31'd0, div_running}, 32'd0);
    chk("mid reset done", {31'd0, done}, 32'd0);
    chk("mid reset result", result, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    start = 1'b0;
    run_op("after reset remu", 2'b11, 32'h1234_5678, 32'h10, 32'd8, 34, 1'b0);
    run_op("after reset divu", 2'b01, 32'h1234_5678, 32'h10, 32'h0123_4567, 34, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
